// File: rtl/gpio_in.sv
// gpio_in: debounced GPIO input block with a small register interface.
// Each pin is synchronized, debounced with a per-bit stable-cycle counter, and
// rising debounced edges are latched into a write-1-to-clear EDGE register.
// Register map (addr[3:2]): 0 DATA (RO), 1 RAW (RO), 2 EDGE (RW1C), 3 MASK (RW).
// Build option: define GPIO_IN_IRQ_EN to include the MASK register and the irq
// output; without it MASK reads 0, ignores writes and irq is tied low.

module gpio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ack,
    output logic             irq
);

    // The counter only ever needs to hold 0 .. DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_RAW  = 2'd1;
    localparam logic [1:0] SEL_EDGE = 2'd2;
    localparam logic [1:0] SEL_MASK = 2'd3;

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] mask_rd;
    logic [1:0]       sel;
    logic             wr;
    logic [31:0]      rd_p0;

    // addr[1:0] are byte-lane bits with no meaning here; upper wdata bits are unused.
    logic unused_bus;
    assign unused_bus = ^{addr[1:0], wdata};

    assign sel = addr[3:2];
    assign wr  = req & we;
    assign w1c = (wr && sel == SEL_EDGE) ? wdata[WIDTH-1:0] : '0;

    // Two-flop synchronizer for the raw asynchronous pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    // A bit is accepted once it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync_p1[i] != deb_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Accepted bits always move to the sync value, so a rise is accept with sync high.
    assign rise = accept & sync_p1;

    // Per-bit stability counters and the debounced level; the counter clears on
    // acceptance, so it never reaches past CNT_MAX and cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            deb_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_p1[i] == deb_q[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            deb_q <= deb_q ^ accept;
        end
    end

    // EDGE latch: new rising edges take priority over a simultaneous W1C clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~w1c) | rise;
        end
    end

`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] mask_q;

    // MASK register and registered interrupt level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && sel == SEL_MASK) begin
                mask_q <= wdata[WIDTH-1:0];
            end
            irq <= |(edge_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    // Read mux; unused upper bits read back as zero.
    always_comb begin
        rd_p0 = '0;
        case (sel)
            SEL_DATA: rd_p0[WIDTH-1:0] = deb_q;
            SEL_RAW:  rd_p0[WIDTH-1:0] = sync_p1;
            SEL_EDGE: rd_p0[WIDTH-1:0] = edge_q;
            SEL_MASK: rd_p0[WIDTH-1:0] = mask_rd;
            default:  rd_p0 = '0;
        endcase
    end

    // Bus response: one ack per req, data only for reads and only in the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= (req && !we) ? rd_p0 : '0;
        end
    end

endmodule

// File: tb/tb_gpio_in.sv
// tb_gpio_in: directed bench for gpio_in (WIDTH=4, DEBOUNCE_CYCLES=4).
// Bus expectations are queued when a request is driven and checked when ack appears.

module tb_gpio_in;

`ifdef GPIO_IN_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pin;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    gpio_in #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pin(pin),
        .req(req),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ack(ack),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at the next falling edge and leave req asserted.
    task automatic drive(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input string tag);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req   = 1'b0;
            we    = 1'b0;
            addr  = 4'h0;
            wdata = 32'h0;
        end
    endtask

    // Response monitor: every ack consumes one expectation; rdata is zero otherwise.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL ack_unexpected: observed ack with rdata %h, required no ack", rdata);
            end
            if (exp_q.size() != 0) begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string       t = tag_q.pop_front();
                n_cmp++;
                assert (rdata === e) else begin
                    n_bad++;
                    $error("FAIL %s: observed rdata %h expected %h", t, rdata, e);
                end
            end
        end else begin
            n_cmp++;
            assert (rdata === 32'h0) else begin
                n_bad++;
                $error("FAIL rdata_idle: observed %h expected 00000000", rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        pin   = 4'hF;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = 32'h0;

        // Reset held with all pins high: outputs stay low.
        idle(3);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // Release: debounced level appears 2+DEBOUNCE_CYCLES = 6 cycles later.
        reset = 1'b1;
        idle(4);
        drive(1'b0, 4'h0, 32'h0, 32'h0, "data_before_settle");
        drive(1'b0, 4'h0, 32'h0, 32'hF, "data_after_release");
        drive(1'b0, 4'h8, 32'h0, 32'hF, "edge_after_release");
        drive(1'b1, 4'h8, 32'hF, 32'h0, "w1c_all_ack");
        drive(1'b0, 4'h8, 32'h0, 32'h0, "edge_cleared");
        idle(1);

        // All pins low; falling transitions do not set EDGE.
        pin = 4'h0;
        idle(10);
        drive(1'b0, 4'h0, 32'h0, 32'h0, "data_all_low");
        drive(1'b0, 4'h8, 32'h0, 32'h0, "edge_no_fall");
        idle(1);

        // 3-cycle glitch on pin[0] is rejected.
        pin = 4'h1;
        idle(3);
        pin = 4'h0;
        idle(10);
        drive(1'b0, 4'h0, 32'h0, 32'h0, "glitch_data");
        drive(1'b0, 4'h8, 32'h0, 32'h0, "glitch_edge");
        idle(1);

        // 4-cycle pulse on pin[0] is just long enough to be accepted.
        pin = 4'h1;
        idle(4);
        pin = 4'h0;
        idle(10);
        drive(1'b0, 4'h8, 32'h0, 32'h1, "pulse4_edge");
        drive(1'b1, 4'h8, 32'h1, 32'h0, "pulse4_w1c");
        drive(1'b0, 4'h8, 32'h0, 32'h0, "pulse4_cleared");
        idle(1);

        // pin[2] rises and holds; writes to read-only registers are ignored.
        pin = 4'h4;
        idle(8);
        drive(1'b0, 4'h0, 32'h0, 32'h4, "pin2_data");
        drive(1'b0, 4'h8, 32'h0, 32'h4, "pin2_edge");
        drive(1'b1, 4'h0, 32'h0, 32'h0, "ro_write_data");
        drive(1'b1, 4'h4, 32'h0, 32'h0, "ro_write_raw");
        drive(1'b0, 4'h0, 32'h0, 32'h4, "data_unchanged");
        drive(1'b0, 4'h4, 32'h0, 32'h4, "raw_read");
        drive(1'b1, 4'h8, 32'h4, 32'h0, "pin2_w1c");
        drive(1'b0, 4'h8, 32'h0, 32'h0, "pin2_edge_cleared");

        // MASK register and interrupt timing.
        drive(1'b1, 4'hC, 32'hFFFF_FFF4, 32'h0, "mask_write");
        drive(1'b0, 4'hC, 32'h0, {28'h0, 4'h4 & {4{IRQ_EN}}}, "mask_read");
        idle(1);
        pin = 4'h0;
        idle(10);
        check("irq_idle", {31'h0, irq}, 32'h0);
        pin = 4'h4;
        idle(6);
        check("irq_before_edge", {31'h0, irq}, 32'h0);
        idle(1);
        check("irq_after_edge", {31'h0, irq}, {31'h0, IRQ_EN});
        drive(1'b1, 4'h8, 32'h4, 32'h0, "irq_w1c");
        idle(1);
        check("irq_w1c_cycle", {31'h0, irq}, {31'h0, IRQ_EN});
        idle(1);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // W1C of EDGE[1] lands on the same cycle pin[1] is accepted: set wins.
        pin = 4'h6;
        idle(4);
        drive(1'b1, 4'h8, 32'h2, 32'h0, "collide_w1c");
        idle(1);
        drive(1'b0, 4'h8, 32'h0, 32'h2, "collide_edge");
        idle(1);

        // Back-to-back reads, one ack each.
        drive(1'b0, 4'h0, 32'h0, 32'h6, "b2b_data");
        drive(1'b0, 4'h4, 32'h0, 32'h6, "b2b_raw");
        drive(1'b0, 4'h8, 32'h0, 32'h2, "b2b_edge");
        idle(1);
        idle(2);

        // Reset during a pending access: no ack, state cleared.
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 4'h8;
        wdata = 32'hF;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("midrst_ack", {31'h0, ack}, 32'h0);
        req   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
        reset = 1'b1;
        idle(1);
        drive(1'b0, 4'h8, 32'h0, 32'h0, "post_rst_edge");
        drive(1'b0, 4'hC, 32'h0, 32'h0, "post_rst_mask");
        drive(1'b0, 4'h0, 32'h0, 32'h0, "post_rst_data");
        idle(12);
        drive(1'b0, 4'h0, 32'h0, 32'h6, "post_rst_data_settled");
        drive(1'b0, 4'h8, 32'h0, 32'h6, "post_rst_edge_settled");
        idle(3);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_in.md
GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter WIDTH, default 4, number of input pins (buttons/switches).
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable cycles required to accept a new pin level; legal range 2..2^20.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pin  input  WIDTH  raw asynchronous board inputs.
REQ-006 req  input  1  bus request, one-cycle pulse per access.
REQ-007 we  input  1  write enable, qualified by req.
REQ-008 addr  input  4  byte address; bits [3:2] select register, bits [1:0] ignored.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, valid while ack is high.
REQ-011 ack  output  1  access complete, one-cycle pulse.
REQ-012 irq  output  1  level interrupt to CPU.

Function
REQ-013 Each pin bit SHALL pass through a 2-flop synchronizer; sync value lags pin by 2 cycles.
REQ-014 Per bit, a counter SHALL increment each cycle sync differs from the debounced value and clear to 0 each cycle they match.
REQ-015 When a counter reaches DEBOUNCE_CYCLES-1 while sync still differs, the debounced bit SHALL take the sync value next cycle and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES SHALL NOT change the debounced value; counters SHALL NOT wrap.
REQ-017 A debounced 0->1 transition SHALL set the corresponding EDGE bit in the same cycle the debounced bit updates.
REQ-018 Register map: 0x0 DATA (RO, debounced, zero-extended); 0x4 RAW (RO, synchronized); 0x8 EDGE (RW1C); 0xC MASK (RW, bits [WIDTH-1:0]).
REQ-019 ack SHALL assert exactly one cycle after req; rdata SHALL be registered and valid in that ack cycle, 0 otherwise.
REQ-020 Writes to 0x0/0x4 SHALL be ignored; reads of unused bits SHALL return 0.
REQ-021 Writing 1 to an EDGE bit SHALL clear it; if a new edge and a W1C clear hit the same bit in one cycle, set SHALL win.
REQ-022 A req arriving while ack is high SHALL be serviced normally (back-to-back accesses, one ack per req).
REQ-023 irq SHALL equal OR over (EDGE & MASK), registered, one cycle after the contributing bit changes.

Reset
REQ-024 reset low SHALL immediately force sync flops, counters, DEBOUNCE, EDGE, MASK, rdata, ack and irq to 0.
REQ-025 Reset asserted mid-access SHALL drop the pending ack; no register write SHALL occur.
REQ-026 After reset release, a pin already high SHALL produce a debounced 1 and an EDGE set after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-027 Macro GPIO_IN_IRQ_EN defined: MASK register and irq output SHALL behave per REQ-018/REQ-023.
REQ-028 Macro GPIO_IN_IRQ_EN undefined: MASK storage SHALL be absent, 0xC SHALL read 0 and ignore writes, irq SHALL be constant 0; EDGE still functional.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-029 Reset pulse low with pin=4'hF -> all outputs 0 during reset; DATA reads 0x0000000F 6 cycles after release.
REQ-030 pin[0] high for 3 cycles then low -> DATA stays 0x0, EDGE stays 0x0.
REQ-031 pin[2] rises and holds -> DATA=0x4 and EDGE=0x4 after 6 cycles; write 0x4 to 0x8 -> EDGE reads 0x0.
REQ-032 MASK=0x4, pin[2] edge -> irq high one cycle after EDGE[2] sets; W1C clears irq next cycle; without GPIO_IN_IRQ_EN irq stays 0 and 0xC reads 0.
REQ-033 W1C of EDGE[1] in the same cycle a new pin[1] edge sets it -> EDGE reads 0x2.
REQ-034 Back-to-back reads of 0x0,0x4,0x8 on consecutive cycles -> three ack pulses with correct rdata each.
